// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising checker for the 13-bit LFSR word stream (x^13+x^4+x^3+x+1).
// Define LFSR_CHK_ZERO_DET_EN to reject the all-zero lock-up word and add the zero_err output.
module lfsr_stream_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [12:0]      in_word,
    output logic             in_ready,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic             period_done,
`ifdef LFSR_CHK_ZERO_DET_EN
    output logic             zero_err,
`endif
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {SEEK = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2, LOST = 2'd3} state_t;

    function automatic logic [12:0] lfsr_next(input logic [12:0] s);
        return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    state_t           state_q, state_d;
    logic [12:0]      exp_q, exp_d, seq_q, seq_d;
    logic [3:0]       match_q, match_d, miss_q, miss_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             mism_q, mism_d, period_q, period_d, zero_q, zero_d;
    logic             acc, hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEEK;
            exp_q    <= '0;
            seq_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            err_q    <= '0;
            mism_q   <= 1'b0;
            period_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            seq_q    <= seq_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            mism_q   <= mism_d;
            period_q <= period_d;
            zero_q   <= zero_d;
        end
    end

    assign acc = in_valid & in_ready;
    assign hit = in_word == exp_q;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        seq_d    = seq_q;
        match_d  = match_q;
        miss_d   = miss_q;
        err_d    = err_q;
        mism_d   = 1'b0;
        period_d = 1'b0;
        zero_d   = 1'b0;
        case (state_q)
            SEEK: if (acc) begin
                exp_d   = lfsr_next(in_word);
                match_d = '0;
                state_d = VERIFY;
            end
            VERIFY: if (acc) begin
                if (hit) begin
                    exp_d   = lfsr_next(exp_q);
                    match_d = match_q + 4'd1;
                    if (match_q + 4'd1 == 4'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        seq_d   = '0;
                        miss_d  = '0;
                    end
                end else begin
                    exp_d   = lfsr_next(in_word);
                    match_d = '0;
                end
            end
            LOCKED: if (acc) begin
                // flywheel: once locked the prediction never reseeds from the input
                exp_d    = lfsr_next(exp_q);
                period_d = seq_q == 13'd8190;
                seq_d    = period_d ? '0 : seq_q + 13'd1;
                if (hit) begin
                    miss_d = '0;
                end else begin
                    mism_d = 1'b1;
                    err_d  = &err_q ? err_q : err_q + ERR_W'(1);
                    miss_d = miss_q + 4'd1;
                    if (miss_q + 4'd1 == 4'(LOSS_CNT)) state_d = LOST;
                end
            end
            default: state_d = SEEK;
        endcase
`ifdef LFSR_CHK_ZERO_DET_EN
        if (acc && in_word == 13'd0) begin
            zero_d = 1'b1;
            if (state_q != LOCKED) begin
                state_d = SEEK;
                exp_d   = exp_q;
                match_d = '0;
            end
        end
`endif
    end

    assign in_ready    = state_q != LOST;
    assign locked      = state_q == LOCKED;
    assign mismatch    = mism_q;
    assign err_count   = err_q;
    assign period_done = period_q;
    assign state_o     = state_q;
`ifdef LFSR_CHK_ZERO_DET_EN
    assign zero_err    = zero_q;
`endif
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: directed-vector bench for lfsr_stream_checker.
// Covers lock, flywheel mismatch, loss of lock, VERIFY reseed, period wrap, reset and zero-word rejection.
module tb_lfsr_stream_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [12:0] in_word = '0;
    logic        in_ready, locked, mismatch, period_done;
    logic [15:0] err_count;
    logic [1:0]  state_o;
`ifdef LFSR_CHK_ZERO_DET_EN
    logic        zero_err;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    lfsr_stream_checker dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_word(in_word),
        .in_ready(in_ready),
        .locked(locked),
        .mismatch(mismatch),
        .err_count(err_count),
        .period_done(period_done),
`ifdef LFSR_CHK_ZERO_DET_EN
        .zero_err(zero_err),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] nx(input logic [12:0] s);
        return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic send(input logic [12:0] w);
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [12:0] w;
        int pc, pi;
        do_reset();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_mism", 32'(mismatch), 0);
        chk("rst_period", 32'(period_done), 0);

        send(13'h0001); chk("seed_state", 32'(state_o), 1);
        send(13'h0003); send(13'h0007); send(13'h000E);
        chk("pre_lock_state", 32'(state_o), 1);
        chk("pre_lock_locked", 32'(locked), 0);
        send(13'h001C);
        chk("lock_locked", 32'(locked), 1);
        chk("lock_state", 32'(state_o), 2);
        chk("lock_err", 32'(err_count), 0);

        send(13'h0038); chk("ok_mism", 32'(mismatch), 0);
        send(13'h0070);
        chk("bad_mism", 32'(mismatch), 1);
        chk("bad_err", 32'(err_count), 1);
        chk("bad_locked", 32'(locked), 1);
        send(13'h00E3);
        chk("recover_mism", 32'(mismatch), 0);
        chk("recover_err", 32'(err_count), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_state", 32'(state_o), 2);
            chk("idle_err", 32'(err_count), 1);
        end

        send(13'h1FFF);
        chk("loss1_mism", 32'(mismatch), 1);
        chk("loss1_state", 32'(state_o), 2);
        send(13'h1FFF);
        chk("loss2_err", 32'(err_count), 3);
        chk("loss2_state", 32'(state_o), 2);
        send(13'h1FFF);
        chk("loss3_err", 32'(err_count), 4);
        chk("lost_state", 32'(state_o), 3);
        chk("lost_ready", 32'(in_ready), 0);
        chk("lost_locked", 32'(locked), 0);
        send(13'h1234);
        chk("after_lost_state", 32'(state_o), 0);
        chk("after_lost_ready", 32'(in_ready), 1);
        send(13'h0001); send(13'h0003); send(13'h0007); send(13'h000E);
        chk("relock_pre", 32'(state_o), 1);
        send(13'h001C);
        chk("relock", 32'(state_o), 2);

        do_reset();
        send(13'h0001); send(13'h0003); send(13'h1234);
        chk("reseed_state", 32'(state_o), 1);
        chk("reseed_err", 32'(err_count), 0);
        chk("reseed_mism", 32'(mismatch), 0);
        send(13'h0468); send(13'h08D1); send(13'h11A3);
        chk("reseed_cnt", 32'(state_o), 1);
        send(13'h0346);
        chk("reseed_lock", 32'(state_o), 2);

        w = 13'h0346; pc = 0; pi = -1;
        for (int i = 0; i < 8191; i++) begin
            w = nx(w);
            send(w);
            if (period_done) begin pc++; pi = i; end
        end
        chk("period_pulses", 32'(pc), 1);
        chk("period_index", 32'(pi), 8190);
        w = nx(w);
        send(w ^ 13'h1);
        chk("post_period_err", 32'(err_count), 1);
        chk("post_period_pd", 32'(period_done), 0);

        in_valid = 1'b1; in_word = 13'h1FFF; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_state", 32'(state_o), 0);
        chk("midrst_err", 32'(err_count), 0);
        chk("midrst_mism", 32'(mismatch), 0);
        chk("midrst_locked", 32'(locked), 0);

`ifdef LFSR_CHK_ZERO_DET_EN
        send(13'h0000);
        chk("zero_seek_pulse", 32'(zero_err), 1);
        chk("zero_seek_state", 32'(state_o), 0);
        send(13'h0001);
        chk("zero_clear", 32'(zero_err), 0);
        chk("zero_seed_state", 32'(state_o), 1);
        send(13'h0000);
        chk("zero_verify_state", 32'(state_o), 0);
        chk("zero_verify_pulse", 32'(zero_err), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
